// File: rtl/ro_puf_array.sv
// ---------------------------------------------------------------------------
// ro_puf_array
// Ring-oscillator PUF. Two of N_RINGS free-running LUT rings are enabled,
// their rising edges are counted over a programmable window, and the two
// counts are compared to produce one response bit.
//
// Ports
//   ICE_CLK   in   sole clock, all registers on its rising edge
//   RST       in   synchronous, active-high reset
//   start     in   measurement request, sampled only while idle
//   sel_a     in   index of the first ring
//   sel_b     in   index of the second ring
//   window    in   count window length in ICE_CLK cycles (0 behaves as 1)
//   busy      out  high whenever a measurement is in progress
//   done      out  one-cycle pulse when resp/tie are updated
//   resp      out  1 when count_a > count_b, held until the next done
//   tie       out  1 when count_a == count_b, held until the next done
//   raw_diff  out  count_a - count_b, signed (only with PUF_RAW_COUNT_EN)
//   ICE_LED   out  mirrors resp
//
// Build options
//   PUF_RAW_COUNT_EN  adds the raw_diff output and its subtractor.
//   SYNTHESIS         selects the SB_LUT4 ring chains; otherwise ring_out is
//                     a static stand-in net that a bench can drive.
// ---------------------------------------------------------------------------
module ro_puf_array #(
    parameter int unsigned N_RINGS  = 8,
    parameter int unsigned RING_LEN = 129,
    parameter int unsigned WINDOW_W = 16,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                       ICE_CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic [$clog2(N_RINGS)-1:0] sel_a,
    input  logic [$clog2(N_RINGS)-1:0] sel_b,
    input  logic [WINDOW_W-1:0]        window,
    output logic                       busy,
    output logic                       done,
    output logic                       resp,
    output logic                       tie,
`ifdef PUF_RAW_COUNT_EN
    output logic signed [COUNT_W:0]    raw_diff,
`endif
    output logic                       ICE_LED
);

    localparam int unsigned SEL_W = $clog2(N_RINGS);
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    // Rest level of a disabled ring: NAND outputs 1, then an even number
    // of inverters when RING_LEN is odd.
    localparam logic RING_IDLE = 1'(RING_LEN % 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           settle_q, settle_d;
    logic [WINDOW_W-1:0]  win_cnt_q, win_cnt_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d;
    logic [SEL_W-1:0]     sel_b_q, sel_b_d;
    logic [COUNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic [COUNT_W-1:0]   cnt_b_q, cnt_b_d;
    logic                 resp_q, resp_d;
    logic                 tie_q, tie_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [N_RINGS-1:0]   ring_en_q, ring_en_d;
    logic [N_RINGS-1:0]   sync1_q, sync2_q, edge_q;
    logic [N_RINGS-1:0]   ring_out;
    logic [N_RINGS-1:0]   rise;
`ifdef PUF_RAW_COUNT_EN
    logic signed [COUNT_W:0] raw_diff_q, raw_diff_d;
`endif

    // Ring oscillators: stage 0 is NAND(enable, feedback), the rest invert.
`ifdef SYNTHESIS
    for (genvar i = 0; i < N_RINGS; i++) begin : g_ring
        (* keep *) logic [RING_LEN-1:0] stage;

        (* keep *) SB_LUT4 #(.LUT_INIT(16'h7777)) u_nand (
            .O  (stage[0]),
            .I0 (ring_en_q[i]),
            .I1 (stage[RING_LEN-1]),
            .I2 (1'b0),
            .I3 (1'b0)
        );

        for (genvar j = 1; j < RING_LEN; j++) begin : g_inv
            (* keep *) SB_LUT4 #(.LUT_INIT(16'h5555)) u_inv (
                .O  (stage[j]),
                .I0 (stage[j-1]),
                .I1 (1'b0),
                .I2 (1'b0),
                .I3 (1'b0)
            );
        end

        assign ring_out[i] = stage[RING_LEN-1];
    end
`else
    // A zero-delay model cannot oscillate: idle rings rest at RING_IDLE and
    // enabled rings show the opposite level unless driven externally.
    assign ring_out = ring_en_q ^ {N_RINGS{RING_IDLE}};
`endif

    // Rising edge: synchronised value high while the edge flop still holds 0.
    assign rise = sync2_q & ~edge_q;

    // Next-state, counting and compare logic.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        win_cnt_d = win_cnt_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
`ifdef PUF_RAW_COUNT_EN
        raw_diff_d = raw_diff_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    sel_a_d   = sel_a;
                    sel_b_d   = sel_b;
                    // Remaining COUNT cycles after the first; window 0 counts one cycle.
                    win_cnt_d = (window == '0) ? '0 : window - WINDOW_W'(1);
                    settle_d  = 2'd3;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == 2'd0) begin
                    state_d = S_COUNT;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            S_COUNT: begin
                if (rise[sel_a_q] && (cnt_a_q != CNT_MAX)) begin
                    cnt_a_d = cnt_a_q + COUNT_W'(1);
                end
                if (rise[sel_b_q] && (cnt_b_q != CNT_MAX)) begin
                    cnt_b_d = cnt_b_q + COUNT_W'(1);
                end
                if (win_cnt_q == '0) begin
                    state_d = S_COMPARE;
                end else begin
                    win_cnt_d = win_cnt_q - WINDOW_W'(1);
                end
            end
            S_COMPARE: begin
                resp_d  = (cnt_a_q > cnt_b_q);
                tie_d   = (cnt_a_q == cnt_b_q);
`ifdef PUF_RAW_COUNT_EN
                raw_diff_d = $signed({1'b0, cnt_a_q}) - $signed({1'b0, cnt_b_q});
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        // Only the two selected rings run, and only while settling or counting.
        if ((state_d == S_SETTLE) || (state_d == S_COUNT)) begin
            ring_en_d = (N_RINGS'(1) << sel_a_d) | (N_RINGS'(1) << sel_b_d);
        end else begin
            ring_en_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge ICE_CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            win_cnt_q <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ring_en_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            edge_q    <= '0;
`ifdef PUF_RAW_COUNT_EN
            raw_diff_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            win_cnt_q <= win_cnt_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ring_en_q <= ring_en_d;
            sync1_q   <= ring_out;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
`ifdef PUF_RAW_COUNT_EN
            raw_diff_q <= raw_diff_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign resp    = resp_q;
    assign tie     = tie_q;
    assign ICE_LED = resp_q;
`ifdef PUF_RAW_COUNT_EN
    assign raw_diff = raw_diff_q;
`endif

endmodule

// File: doc/ro_puf_array.md
RO_PUF_ARRAY -- requirements
Module: ro_puf_array

Interface
REQ-001 Parameter N_RINGS, default 8, number of ring oscillators; SHALL be a power of two >= 2.
REQ-002 Parameter RING_LEN, default 129, LUT stages per ring; SHALL be odd and >= 65.
REQ-003 Parameter WINDOW_W, default 16, width of the window input in bits.
REQ-004 Parameter COUNT_W, default 16, width of each edge counter in bits.
REQ-005 ICE_CLK  in  1  sole clock; one clock; every register SHALL be clocked on its rising edge.
REQ-006 RST  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  request a measurement; sampled only in IDLE.
REQ-008 sel_a  in  log2(N_RINGS)  index of the first ring.
REQ-009 sel_b  in  log2(N_RINGS)  index of the second ring.
REQ-010 window  in  WINDOW_W  count window length in ICE_CLK cycles.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse when resp and tie are updated.
REQ-013 resp  out  1  response bit, 1 when count_a > count_b; held until the next done.
REQ-014 tie  out  1  1 when count_a == count_b; held until the next done.
REQ-015 ICE_LED  out  1  mirrors resp.

Function
REQ-016 Each ring SHALL be a chain of RING_LEN kept SB_LUT4 cells: stage 0 is NAND(enable, feedback) and the rest are inverters; internal net ring_out[N_RINGS-1:0] carries the last stage of each ring.
REQ-017 Only rings sel_a and sel_b SHALL be enabled, and only in SETTLE and COUNT; all other rings SHALL be held static.
REQ-018 Each ring_out SHALL pass through a 2-flop synchroniser plus one edge flop; a rising edge SHALL be counted when the synchronised value is 1 and the edge flop holds 0.
REQ-019 FSM states SHALL be IDLE, SETTLE, COUNT, COMPARE and DONE.
REQ-020 IDLE -> SETTLE on start=1; sel_a, sel_b and window SHALL be latched on that cycle, and counters SHALL clear.
REQ-021 SETTLE SHALL last exactly 4 cycles with counting disabled, then move to COUNT.
REQ-022 COUNT SHALL last max(window,1) cycles, and edges SHALL be counted only in these cycles.
REQ-023 Counters SHALL saturate at 2^COUNT_W-1 and never wrap.
REQ-024 COMPARE (1 cycle) SHALL compute resp and tie, register them, and then move to DONE.
REQ-025 DONE (1 cycle) SHALL assert done and then return to IDLE.
REQ-026 With start in cycle 0, done SHALL be high in cycle 6+max(window,1), and busy SHALL be high in cycles 1 through 6+max(window,1).
REQ-027 start while busy SHALL be ignored, with no queuing.
REQ-028 sel_a == sel_b SHALL yield resp=0 and tie=1.
REQ-029 A tie SHALL yield resp=0.
REQ-030 Input changes after acceptance SHALL have no effect on the measurement in progress.

Reset
REQ-031 With RST=1 at a clock edge, the FSM SHALL go to IDLE and all counters, synchronisers, resp, tie, done, busy and ICE_LED SHALL be 0, with all rings disabled.
REQ-032 Reset mid-measurement SHALL abort it with no done pulse, and resp and tie SHALL be cleared.
REQ-033 start asserted in the same cycle as RST SHALL be ignored.

Configuration
REQ-034 When macro PUF_RAW_COUNT_EN is defined, output raw_diff (signed, COUNT_W+1 bits) SHALL equal count_a - count_b, registered with resp in COMPARE and reset to 0.
REQ-035 When PUF_RAW_COUNT_EN is undefined, the raw_diff port and its subtractor SHALL be absent, and all other behaviour SHALL be identical.

Verification (bench forces ring_out[] synchronously to ICE_CLK)
REQ-036 Force ring 2 with period 8 clk and ring 5 with period 4 clk; sel_a=2, sel_b=5, window=80 -> done at cycle 86, resp=0, tie=0, raw_diff=-10.
REQ-037 Same forcing with sel_a=5 and sel_b=2 -> resp=1, ICE_LED=1, raw_diff=+10.
REQ-038 sel_a=sel_b=3, window=40 -> resp=0, tie=1, raw_diff=0.
REQ-039 window=0 -> done at cycle 7 and the count window is 1 cycle; start pulsed at cycle 3 while busy -> no second measurement.
REQ-040 RST asserted at cycle 20 of an 80-cycle window -> next cycle busy=0, resp=tie=0, and no done pulse follows.
REQ-041 COUNT_W=4, ring forced with period 2 clk, window=100 -> count saturates at 15 with no wrap; versus a static ring -> resp=1.
